cp0_reg: RTL
============

CP0_REG -- requirements
Module: cp0_reg

Interface
- REQ-001: Parameter PRID_VALUE, default 32'h004C_0102, value of the read-only PRId register.
- REQ-002: Parameter CONFIG_RESET, default 32'h0000_8000 (BE=1), reset value of Config.
- REQ-003: clk  in  1  clock; all state updates on rising edge.
- REQ-004: rst  in  1  reset, synchronous, active-high.
- REQ-005: we_i  in  1  write enable from the write-back stage (the registered cp0 write enable of the memory/write-back register).
- REQ-006: waddr_i  in  5  CP0 register number to write.
- REQ-007: data_i  in  32  write data.
- REQ-008: raddr_i  in  5  CP0 register number to read.
- REQ-009: int_i  in  6  external hardware interrupt lines.
- REQ-010: excepttype_i  in  32  exception code from the memory stage; 0 = none.
- REQ-011: current_inst_addr_i  in  32  PC of the excepting instruction.
- REQ-012: is_in_delayslot_i  in  1  excepting instruction is in a delay slot.
- REQ-013: data_o  out  32  read data for raddr_i.
- REQ-014: count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  live register values.
- REQ-015: timer_int_o  out  1  timer interrupt request.

Function
- REQ-016: Register numbers: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
- REQ-017: data_o is combinational from the current register values; unmapped raddr_i returns 0; no write-to-read bypass.
- REQ-018: Count increments by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
- REQ-019: A write to Count loads data_i and overrides that cycle's increment.
- REQ-020: Cause[15:10] is loaded from int_i every cycle, regardless of writes.
- REQ-021: timer_int_o is set the cycle after Count == Compare while Compare != 0, and stays set until Compare is written.
- REQ-022: A write to Compare loads data_i and clears timer_int_o in the same edge; on a same-cycle match, the clear wins.
- REQ-023: Status and EPC writes load all 32 bits.
- REQ-024: Cause writes update only IP[9:8], WP[22] and IV[23].
- REQ-025: Writes to PRId, Config and unmapped addresses are ignored.
- REQ-026: Exception codes and ExcCode: 0x1 interrupt -> 0; 0x8 syscall -> 8; 0xa reserved instruction -> 10; 0xc overflow -> 12; 0xd trap -> 13; 0xe eret.
- REQ-027: Non-eret exception with Status.EXL=0: EPC <= current_inst_addr_i-4 and Cause.BD <= 1 if is_in_delayslot_i, else EPC <= current_inst_addr_i and BD <= 0.
- REQ-028: Non-eret exception with Status.EXL=1: EPC and BD are unchanged.
- REQ-029: Every non-eret exception: Status.EXL <= 1 and Cause[6:2] <= ExcCode.
- REQ-030: eret: Status.EXL <= 0; no other field changes.
- REQ-031: Unlisted nonzero excepttype_i values are ignored.
- REQ-032: On a same-cycle exception and software write to Status, Cause or EPC, exception-updated fields win; all other fields take the write.

Reset
- REQ-033: Reset values: Count 0, Compare 0, Status 32'h1000_0000 (CU0=1), Cause 0, EPC 0, Config CONFIG_RESET, timer_int_o 0.
- REQ-034: prid_o is always PRID_VALUE.
- REQ-035: Reset mid-operation discards any same-cycle write or exception.

Structure
- REQ-036: The shared defines file holds the CP0 register numbers, exception type codes, RstEnable/WriteEnable and ZeroWord; no new constants are local to this module.
- REQ-037: The module is a single flat block with no sub-modules.

Verification
- REQ-038: Reset, then idle 5 cycles -> count_o=5, status_o=32'h1000_0000, data_o(raddr 15)=PRID_VALUE.
- REQ-039: Write Compare=20 at count 10 -> timer_int_o rises at count 21; a later write of Compare=40 clears it on that edge.
- REQ-040: excepttype 0x8, pc 0x100, delayslot=1 -> epc_o=0xFC, cause BD=1, ExcCode=8, EXL=1; a following 0xa exception leaves EPC=0xFC and sets ExcCode=10.
- REQ-041: excepttype 0xe with EXL=1 -> EXL=0, EPC unchanged.
- REQ-042: Write Cause=32'hFFFF_FFFF with int_i=6'b000001 -> cause_o=32'h00C0_0700.
- REQ-043: Write Count=32'hFFFF_FFFF -> count_o=0 on the next cycle; a Status write plus a same-cycle syscall exception -> EXL=1 with the other Status bits taken from the write.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg: shared CP0 register numbers, exception type codes and common constants
package cp0_reg_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [4:0] CP0_REG_COUNT = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC = 5'd14;
  localparam logic [4:0] CP0_REG_PRID = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG = 5'd16;
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD = 31;

  // {valid, ExcCode} for a non-eret exception type; valid=0 for none/eret/unlisted
  function automatic logic [5:0] exc_decode(input logic [31:0] t);
    case (t)
      EXC_INTERRUPT: exc_decode = {1'b1, 5'd0};
      EXC_SYSCALL: exc_decode = {1'b1, 5'd8};
      EXC_INST_INVALID: exc_decode = {1'b1, 5'd10};
      EXC_OVERFLOW: exc_decode = {1'b1, 5'd12};
      EXC_TRAP: exc_decode = {1'b1, 5'd13};
      default: exc_decode = 6'd0;
    endcase
  endfunction
endpackage

// File: rtl/cp0_reg.sv
// cp0_reg: MIPS coprocessor-0 register file with timer, exception and eret handling
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h004C_0102,
  parameter logic [31:0] CONFIG_RESET = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);
  logic [31:0] r_count, r_compare, r_status, r_cause, r_epc;
  logic        r_timer_int;
  logic [31:0] w_status_n, w_cause_n, w_epc_n;
  logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
  logic [5:0]  w_exc;
  logic        w_eret;

  assign w_wr_count = we_i == WriteEnable && waddr_i == CP0_REG_COUNT;
  assign w_wr_compare = we_i == WriteEnable && waddr_i == CP0_REG_COMPARE;
  assign w_wr_status = we_i == WriteEnable && waddr_i == CP0_REG_STATUS;
  assign w_wr_cause = we_i == WriteEnable && waddr_i == CP0_REG_CAUSE;
  assign w_wr_epc = we_i == WriteEnable && waddr_i == CP0_REG_EPC;
  assign w_exc = exc_decode(excepttype_i);
  assign w_eret = excepttype_i == EXC_ERET;

  // software write first, then exception/eret fields layered on top so they win
  always_comb begin
    w_status_n = w_wr_status ? data_i : r_status;
    w_epc_n = w_wr_epc ? data_i : r_epc;
    w_cause_n = r_cause;
    w_cause_n[23:22] = w_wr_cause ? data_i[23:22] : r_cause[23:22];
    w_cause_n[9:8] = w_wr_cause ? data_i[9:8] : r_cause[9:8];
    w_cause_n[15:10] = int_i;
    if (w_exc[5]) begin
      if (!r_status[STATUS_EXL]) begin
        w_epc_n = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        w_cause_n[CAUSE_BD] = is_in_delayslot_i;
      end
      w_status_n[STATUS_EXL] = 1'b1;
      w_cause_n[6:2] = w_exc[4:0];
    end else if (w_eret) begin
      w_status_n[STATUS_EXL] = 1'b0;
    end
  end

  // register update; reset discards any same-cycle write or exception
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_count <= ZeroWord;
      r_compare <= ZeroWord;
      r_status <= STATUS_RESET;
      r_cause <= ZeroWord;
      r_epc <= ZeroWord;
      r_timer_int <= 1'b0;
    end else begin
      r_count <= w_wr_count ? data_i : r_count + 32'd1;
      r_compare <= w_wr_compare ? data_i : r_compare;
      r_timer_int <= w_wr_compare ? 1'b0 :
                     (r_compare != ZeroWord && r_count == r_compare) ? 1'b1 : r_timer_int;
      r_status <= w_status_n;
      r_cause <= w_cause_n;
      r_epc <= w_epc_n;
    end
  end

  assign data_o = raddr_i == CP0_REG_COUNT ? r_count :
                  raddr_i == CP0_REG_COMPARE ? r_compare :
                  raddr_i == CP0_REG_STATUS ? r_status :
                  raddr_i == CP0_REG_CAUSE ? r_cause :
                  raddr_i == CP0_REG_EPC ? r_epc :
                  raddr_i == CP0_REG_PRID ? PRID_VALUE :
                  raddr_i == CP0_REG_CONFIG ? CONFIG_RESET : ZeroWord;
  assign count_o = r_count;
  assign compare_o = r_compare;
  assign status_o = r_status;
  assign cause_o = r_cause;
  assign epc_o = r_epc;
  assign config_o = CONFIG_RESET;
  assign prid_o = PRID_VALUE;
  assign timer_int_o = r_timer_int;
endmodule
